mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 94 +++++++++
 tb/tb_mdu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: issues multicycle ops to an external datapath,
// owns the HI/LO registers and generates busy/stall for the pipeline.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 5,  // 1..15
  parameter int unsigned DIV_LAT = 10  // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  input  logic        d_is_mdu,
  output logic [1:0]  dp_op,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] dp_hi,
  input  logic [31:0] dp_lo,
  output logic [31:0] mdu_out,
  output logic        busy,
  output logic        stall,
  output logic        protocol_err
);

  localparam logic [3:0] OpMfhi = 4'd5;
  localparam logic [3:0] OpMtlo = 4'd6;
  localparam logic [3:0] OpMthi = 4'd7;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        issue;
  logic        is_muldiv;
  logic        div_by_zero;

  assign issue       = op_valid & ~req & (state_q == StIdle);
  assign is_muldiv   = (op[3:2] == 2'b00);
  assign div_by_zero = dp_op[1] & (dp_b == 32'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      dp_op        <= 2'd0;
      dp_a         <= 32'd0;
      dp_b         <= 32'd0;
      protocol_err <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            if (is_muldiv) begin
              state_q <= StRun;
              dp_op   <= op[1:0];
              dp_a    <= rs_val;
              dp_b    <= rt_val;
              cnt_q   <= op[1] ? 4'(DIV_LAT) : 4'(MUL_LAT);
            end else if (op == OpMtlo) begin
              lo_q <= rs_val;
            end else if (op == OpMthi) begin
              hi_q <= rs_val;
            end
          end
        end
        StRun: begin
          // The pipeline should hold MDU ops in D while busy; one reaching E is a bug.
          if (op_valid && !req) begin
            protocol_err <= 1'b1;
          end
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            if (!div_by_zero) begin
              hi_q <= dp_hi;
              lo_q <= dp_lo;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StRun);
  assign stall   = d_is_mdu & (busy | (issue & is_muldiv));
  assign mdu_out = (op == OpMfhi) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: behavioural datapath model plus a HI/LO scoreboard
// whose expectations are queued at issue and compared once the result is readable.
module tb_mdu_ctrl;

  localparam int unsigned MulLat = 5;
  localparam int unsigned DivLat = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req;
  logic        d_is_mdu;
  logic [1:0]  dp_op;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic [31:0] dp_hi;
  logic [31:0] dp_lo;
  logic [31:0] mdu_out;
  logic        busy;
  logic        stall;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  always #5 clk = ~clk;

  mdu_ctrl #(
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .req         (req),
    .d_is_mdu    (d_is_mdu),
    .dp_op       (dp_op),
    .dp_a        (dp_a),
    .dp_b        (dp_b),
    .dp_hi       (dp_hi),
    .dp_lo       (dp_lo),
    .mdu_out     (mdu_out),
    .busy        (busy),
    .stall       (stall),
    .protocol_err(protocol_err)
  );

  // Datapath model; divide-by-zero returns junk so a wrong capture is visible.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  always_comb begin
    prod_s = $signed({{32{dp_a[31]}}, dp_a}) * $signed({{32{dp_b[31]}}, dp_b});
    prod_u = {32'd0, dp_a} * {32'd0, dp_b};
    dp_hi  = 32'hDEADBEEF;
    dp_lo  = 32'hDEADBEEF;
    case (dp_op)
      2'd0: {dp_hi, dp_lo} = prod_s;
      2'd1: {dp_hi, dp_lo} = prod_u;
      2'd2: if (dp_b != 32'd0) begin
        dp_lo = $signed(dp_a) / $signed(dp_b);
        dp_hi = $signed(dp_a) % $signed(dp_b);
      end
      default: if (dp_b != 32'd0) begin
        dp_lo = dp_a / dp_b;
        dp_hi = dp_a % dp_b;
      end
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_hilo();
    sb_q.push_back(exp_hi);
    sb_q.push_back(exp_lo);
  endtask

  // Pops the expected HI then LO and reads them back via MFHI/MFLO.
  task automatic read_hilo(input string tag);
    logic [31:0] e;
    checks++;
    assert (sb_q.size() >= 2)
    else begin
      errors++;
      $error("FAIL %s_sb: observed %0d queued expected 2", tag, sb_q.size());
    end
    if (sb_q.size() >= 2) begin
      op = 4'd5;
      #1;
      e = sb_q.pop_front();
      chk({tag, "_hi"}, mdu_out, e);
      op = 4'd4;
      #1;
      e = sb_q.pop_front();
      chk({tag, "_lo"}, mdu_out, e);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    req      = r;
    cyc();
    op_valid = 1'b0;
    req      = 1'b0;
  endtask

  // Counts remaining busy cycles; operands are scribbled to prove the latch holds.
  task automatic run_wait(input string tag, input int exp_n, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [1:0] eop);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      chk({tag, "_dp_a"}, dp_a, ea);
      chk({tag, "_dp_b"}, dp_b, eb);
      chk({tag, "_dp_op"}, {30'd0, dp_op}, {30'd0, eop});
      rs_val = $urandom();
      rt_val = $urandom();
      cyc();
    end
    chk({tag, "_busy_cycles"}, n, exp_n);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    op_valid = 1'b0;
    op       = 4'd5;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    req      = 1'b0;
    d_is_mdu = 1'b1;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
    repeat (2) cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_perr", protocol_err, 1'b0);
    chk("rst_dp_a", dp_a, 32'd0);
    chk("rst_dp_b", dp_b, 32'd0);
    chk("rst_dp_op", {30'd0, dp_op}, 32'd0);
    push_hilo();
    read_hilo("rst");
    reset    = 1'b1;
    d_is_mdu = 1'b0;
    cyc();

    // Squashed ops: MTLO and MULT with req=1 leave no trace.
    drive(4'd6, 32'h12345678, 32'd0, 1'b1);
    chk("mtlo_req_busy", busy, 1'b0);
    push_hilo();
    read_hilo("mtlo_req");
    drive(4'd0, 32'd5, 32'd6, 1'b1);
    chk("mult_req_busy", busy, 1'b0);
    chk("mult_req_dp_a", dp_a, 32'd0);

    // MTLO: no stall, no busy, visible next cycle.
    d_is_mdu = 1'b1;
    op_valid = 1'b1;
    op       = 4'd6;
    rs_val   = 32'h12345678;
    #1;
    chk("mtlo_stall", stall, 1'b0);
    cyc();
    op_valid = 1'b0;
    d_is_mdu = 1'b0;
    chk("mtlo_busy", busy, 1'b0);
    exp_lo = 32'h12345678;
    push_hilo();
    read_hilo("mtlo");

    // Signed MULT -2 * 3.
    drive(4'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    exp_hi = 32'hFFFFFFFF;
    exp_lo = 32'hFFFFFFFA;
    push_hilo();
    run_wait("mult", MulLat, 32'hFFFFFFFE, 32'd3, 2'd0);
    read_hilo("mult");

    // DIVU 7/2 with D-stage MDU op: stall for issue cycle plus DIV_LAT.
    d_is_mdu = 1'b1;
    op_valid = 1'b1;
    op       = 4'd3;
    rs_val   = 32'd7;
    rt_val   = 32'd2;
    n        = 0;
    #1;
    while (stall === 1'b1 && n < 40) begin
      n++;
      cyc();
      op_valid = 1'b0;
      #1;
    end
    chk("divu_stall_cycles", n, 1 + DivLat);
    chk("divu_busy_after", busy, 1'b0);
    d_is_mdu = 1'b0;
    exp_hi = 32'd1;
    exp_lo = 32'd3;
    push_hilo();
    read_hilo("divu");

    // MTHI then DIV by zero: full latency, HI/LO untouched.
    drive(4'd7, 32'h000000AA, 32'd0, 1'b0);
    exp_hi = 32'h000000AA;
    drive(4'd2, 32'd5, 32'd0, 1'b0);
    push_hilo();
    run_wait("div0", DivLat, 32'd5, 32'd0, 2'd2);
    read_hilo("div0");
    chk("div0_perr", protocol_err, 1'b0);

    // MTHI arriving during RUN is ignored and flags protocol_err.
    drive(4'd3, 32'd9, 32'd0, 1'b0);
    op_valid = 1'b1;
    op       = 4'd7;
    rs_val   = 32'h00000055;
    cyc();
    op_valid = 1'b0;
    chk("perr_set", protocol_err, 1'b1);
    push_hilo();
    run_wait("perr_run", DivLat - 1, 32'd9, 32'd0, 2'd3);
    read_hilo("perr");
    chk("perr_sticky", protocol_err, 1'b1);

    // Reset during RUN cycle 3 aborts with no later capture.
    drive(4'd0, 32'd3, 32'd4, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("rstrun_busy", busy, 1'b0);
    chk("rstrun_perr", protocol_err, 1'b0);
    chk("rstrun_dp_a", dp_a, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    push_hilo();
    read_hilo("rstrun");
    repeat (8) cyc();
    chk("rstrun_late_busy", busy, 1'b0);
    push_hilo();
    read_hilo("rstrun_late");

    // Back-to-back: result readable and new op accepted in the cycle busy falls.
    drive(4'd1, 32'h00010000, 32'h00010000, 1'b0);
    exp_hi = 32'd1;
    exp_lo = 32'd0;
    push_hilo();
    run_wait("multu", MulLat, 32'h00010000, 32'h00010000, 2'd1);
    read_hilo("multu");
    drive(4'd1, 32'd7, 32'd6, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_perr", protocol_err, 1'b0);
    exp_hi = 32'd0;
    exp_lo = 32'd42;
    push_hilo();
    run_wait("b2b", MulLat, 32'd7, 32'd6, 2'd1);
    read_hilo("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
